// File: rtl/imm_encoder.sv
// imm_encoder: packs a signed immediate into the I/S/B/J bit positions
// of an instruction word and merges it with caller-supplied fields.
module imm_encoder #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           ImmFormat,
  input  logic [31:0]          imm_in,
  input  logic [31:7]          base_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:7]          bits_out,
  output logic [1:0]           fmt_out,
  output logic                 imm_err,
  output logic [ERR_CNT_W-1:0] err_count,
  input  logic                 err_clr
);

  typedef enum logic [1:0] {
    FMT_I = 2'b00,
    FMT_S = 2'b01,
    FMT_B = 2'b10,
    FMT_J = 2'b11
  } fmt_e;

  fmt_e fmt;
  assign fmt = fmt_e'(ImmFormat);

  // Sign-extension checks: the upper bits must all equal the sign bit.
  logic is_ok;
  logic b_ok;
  logic j_ok;
  assign is_ok = (&imm_in[31:11]) | ~(|imm_in[31:11]);
  assign b_ok  = (&imm_in[31:12]) | ~(|imm_in[31:12]);
  assign j_ok  = (&imm_in[31:20]) | ~(|imm_in[31:20]);

  logic [31:7] swz;
  logic [31:7] msk;
  logic        err;

  // Scramble the immediate into its format's bit positions and flag range errors.
  always_comb begin
    swz = '0;
    msk = '0;
    err = 1'b0;
    unique case (fmt)
      FMT_I: begin
        swz[31:20] = imm_in[11:0];
        msk[31:20] = '1;
        err        = ~is_ok;
      end
      FMT_S: begin
        swz[31:25] = imm_in[11:5];
        swz[11:7]  = imm_in[4:0];
        msk[31:25] = '1;
        msk[11:7]  = '1;
        err        = ~is_ok;
      end
      FMT_B: begin
        swz[31]    = imm_in[12];
        swz[30:25] = imm_in[10:5];
        swz[11:8]  = imm_in[4:1];
        swz[7]     = imm_in[11];
        msk[31:25] = '1;
        msk[11:7]  = '1;
        err        = ~b_ok | imm_in[0];
      end
      FMT_J: begin
        swz[31]    = imm_in[20];
        swz[30:21] = imm_in[10:1];
        swz[20]    = imm_in[11];
        swz[19:12] = imm_in[19:12];
        msk[31:12] = '1;
        err        = ~j_ok | imm_in[0];
      end
    endcase
  end

  logic        s1_valid;
  logic [31:7] s1_swz;
  logic [31:7] s1_msk;
  logic [31:7] s1_base;
  logic [1:0]  s1_fmt;
  logic        s1_err;

  logic        s2_valid;
  logic [31:7] s2_bits;
  logic [1:0]  s2_fmt;
  logic        s2_err;

  logic s1_load;
  logic s2_load;

  assign s2_load  = ~s2_valid | out_ready;
  assign s1_load  = ~s1_valid | s2_load;
  assign in_ready = s1_load;

  // Stage 1: capture the scrambled fields, mask, base and error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_swz   <= '0;
      s1_msk   <= '0;
      s1_base  <= '0;
      s1_fmt   <= '0;
      s1_err   <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_swz  <= swz;
        s1_msk  <= msk;
        s1_base <= base_in;
        s1_fmt  <= ImmFormat;
        s1_err  <= err;
      end
    end
  end

  logic [31:7] merged;
  assign merged = (s1_swz & s1_msk) | (s1_base & ~s1_msk);

  // Stage 2: register the merged word; holds while the consumer stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_bits  <= '0;
      s2_fmt   <= '0;
      s2_err   <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_bits <= merged;
        s2_fmt  <= s1_fmt;
        s2_err  <= s1_err;
      end
    end
  end

  assign out_valid = s2_valid;
  assign bits_out  = s2_bits;
  assign fmt_out   = s2_fmt;
  assign imm_err   = s2_err;

  logic cnt_sat;
  logic cnt_inc;
  assign cnt_sat = &err_count;
  assign cnt_inc = s2_valid & out_ready & s2_err & ~cnt_sat;

  // Saturating count of consumed errored results; clear wins over increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= '0;
    end else if (cnt_inc) begin
      err_count <= err_count + ERR_CNT_W'(1);
    end
  end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the decode-stage immediate extender: packs a 32-bit signed immediate into the scrambled I/S/B/J bit positions of an instruction word.
- Merges the packed immediate into caller-supplied non-immediate fields.
- Used by the debug instruction-injection path and the self-test program generator.
- 2-stage valid/ready pipeline with range/alignment checking and a saturating error counter.

Parameters:
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid & in_ready.
- ImmFormat  input  2  00=I, 01=S, 10=B, 11=J.
- imm_in  input  32  signed immediate (byte offset for B/J).
- base_in  input  25 [31:7]  non-immediate fields (rs1/rs2/rd/funct); bits in immediate positions are ignored.
- out_valid  output  1  result valid.
- out_ready  input  1  result consumed when out_valid & out_ready.
- bits_out  output  25 [31:7]  base_in with immediate fields overwritten.
- fmt_out  output  2  format of the result, passed through.
- imm_err  output  1  immediate out of range or misaligned for fmt_out.
- err_count  output  ERR_CNT_W  count of errored results consumed.
- err_clr  input  1  synchronous clear of err_count.

Behaviour:
- Reset (async, active-high): both stage valids=0, out_valid=0, bits_out=0, fmt_out=0, imm_err=0, err_count=0. in_ready=1 out of reset.
- Pipeline: S1 registers the swizzled fields, a field mask, base_in, fmt and err; S2 registers the merged word. bits_out/fmt_out/imm_err are driven from S2 registers only.
- Latency: request accepted at edge k gives out_valid high after edge k+1 (2 cycles).
- Throughput: 1 result/cycle when out_ready is held high.
- Stall rules:
  - S2 loads when ~s2_valid | out_ready.
  - S1 loads when ~s1_valid | s2 loads.
  - in_ready = ~s1_valid | s2 loads (combinational).
  - No bubbles are inserted while unstalled.
- Stalled payload: while out_valid & ~out_ready, bits_out/fmt_out/imm_err are held stable. No request is dropped or duplicated.
- Packing (bit positions of bits_out):
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
  - All other bits come from base_in.
- Range checks (imm_err=1 if violated):
  - I/S: imm[31:11] all equal (12-bit signed).
  - B: imm[31:12] all equal and imm[0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
- Errored requests are still packed, using truncated low bits, and propagated normally.
- Round-trip property: for every non-errored request, the decode-stage extender applied to bits_out/fmt_out returns imm_in exactly.
- err_count:
  - Increments by 1 on each cycle where out_valid & out_ready & imm_err.
  - Saturates at 2^ERR_CNT_W-1.
  - err_clr has priority: a simultaneous clear and increment yields 0.
- Reset mid-operation: in-flight requests are discarded and outputs return to reset values immediately (asynchronously).

Test Plan:
- I, imm_in=0xFFFFFFFF, base_in=0 -> 2 cycles later bits_out[31:20]=0xFFF, bits_out[19:7]=0, imm_err=0.
- B, imm_in=0x00000800, base_in=0x1FFFFFF -> bits_out[7]=1, bits_out[31]=0, [30:25]=0, [11:8]=0, other bits=1, imm_err=0. Same request with imm_in=0x801 -> imm_err=1.
- J, imm_in=0xFFF00000 -> bits_out=0x1000000 (bit31 only), imm_err=0. J, imm_in=0x00100000 -> imm_err=1.
- Back-to-back 8 requests with out_ready toggling 1,0,0,1,... -> all 8 results in order, payload stable during stalls, in_ready low when both stages are full.
- Random formats/in-range immediates, 10k vectors -> round-trip through the extender equals imm_in. 300 errored S requests (imm_in=0x800) -> err_count stops at 255. Pulse err_clr together with an errored handshake -> err_count=0.
- Assert reset with 2 requests in flight -> out_valid=0 and err_count=0 asynchronously; no stale result appears after reset deasserts.
